// File: rtl/button_event_decoder_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event decoder: the two-bit state
// encoding, the FSM state type built on that encoding, and the helper
// that sizes the single hold/repeat cycle counter.
// Ports: none (package).
// ---------------------------------------------------------------------------
package button_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_REPEAT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PRESSED = ST_PRESSED,
    REPEAT  = ST_REPEAT
  } state_e;

  // The counter must reach the larger of the two terminal values; at least
  // one bit is kept so the counter is always a legal vector.
  function automatic int cnt_width(input int hold_cycles, input int repeat_cycles);
    int m;
    m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// ---------------------------------------------------------------------------
// button_event_decoder_if
// Groups the debounced button level and the decoded event outputs.
//   btn_level     : debounced level, 1 = pressed (driven by the master)
//   press_pulse   : one-cycle pulse on each press
//   release_pulse : one-cycle pulse on each release
//   click_pulse   : one-cycle pulse on a release before the long threshold
//   long_pulse    : one-cycle pulse when the hold reaches the threshold
//   repeat_pulse  : paced one-cycle pulses while held after long_pulse
//   held          : level, high while the button is considered held
// master = source of btn_level / consumer of events, slave = the decoder.
// ---------------------------------------------------------------------------
interface button_event_decoder_if;

  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output btn_level,
    input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  btn_level,
    output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
// Turns the debounced level of one push-button into single-cycle events:
// press, release, short click, long press and auto-repeat.
// Parameters:
//   HOLD_CYCLES   : cycles from press_pulse to long_pulse (>= 2)
//   REPEAT_CYCLES : cycles between repeat pulses after long_pulse (>= 1)
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus_if : button_event_decoder_if.slave (btn_level in, events out)
// ---------------------------------------------------------------------------
module button_event_decoder
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_event_decoder_if.slave  bus_if
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, REPEAT_CYCLES);

  // cnt counts edges elapsed since the last press/long/repeat event, so the
  // terminal values land the long event HOLD_CYCLES cycles after press_pulse
  // and each repeat event REPEAT_CYCLES cycles after its predecessor.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             held_q, held_d;

  // Next-state logic: decides the next FSM state, the next counter value
  // and which event pulse (if any) gets registered for the following cycle.
  // A release always takes priority over a terminal count, so a button let
  // go exactly at the threshold still counts as a click.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_if.btn_level) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!bus_if.btn_level) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!bus_if.btn_level) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  // State, counter and every output live in one register bank, so all
  // outputs come straight from flops and reset clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign bus_if.press_pulse   = press_q;
  assign bus_if.release_pulse = release_q;
  assign bus_if.click_pulse   = click_q;
  assign bus_if.long_pulse    = long_q;
  assign bus_if.repeat_pulse  = repeat_q;
  assign bus_if.held          = held_q;

endmodule
